harmonic_sequencer: RTL and testbench
=====================================

Name: harmonic_sequencer

Overview:
Time-multiplexes one shared sine ROM across three harmonic phase accumulators at 1x, 2x and 3x the fundamental step. On each accepted sample request it fetches the three harmonic samples in sequence and applies the selected harmonic weighting. It then presents one registered signed sample with a single-cycle ready pulse. It sits between the note player (step_size, weight, play/done controls) and the codec sample path, replacing three parallel sine readers with one ROM port.

Parameters:
PHASE_W, 20, phase accumulator and step width (10 integer + 10 fractional bits)
ADDR_W, 10, sine ROM address width; the address is phase[PHASE_W-1 -: ADDR_W]

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
play_enable  input  1  playback enabled; requests are ignored when low
generate_next_sample  input  1  sample request strobe from the codec side
note_done  input  1  current note finished; phases clear in IDLE
step_size  input  PHASE_W  fundamental phase increment per sample
weight  input  2  harmonic mix select (0, 1, 2; 3 aliases 2)
rom_addr  output  ADDR_W  shared sine ROM address (full-wave table, registered read, 1-cycle latency)
rom_data  input  16  signed ROM data for the address presented on the previous cycle
busy  output  1  high in every state except IDLE
harmonic_out  output  16  signed weighted sample; held between updates
sample_ready  output  1  one-cycle pulse when harmonic_out updates

Behaviour:
- Reset: state IDLE; all three phases = 0; harmonic_out = 0; sample_ready = 0; busy = 0; rom_addr = 0. Reset in any state aborts the sequence immediately, with no sample_ready.
- go = generate_next_sample && play_enable && !note_done. go is sampled only in IDLE and ignored (dropped) in every other state; busy requests are not queued.
- On accepted go (cycle t), the block latches weight and updates the phases:
  - p1 += step
  - p2 += step<<1
  - p3 += step + (step<<1)
  - All sums are modulo 2^PHASE_W; the step products are truncated to PHASE_W bits.
- State sequence IDLE -> RD1 -> RD2 -> RD3 -> CAP -> DONE -> IDLE, one cycle each:
  - RD1 (t+1): rom_addr = p1 top bits.
  - RD2 (t+2): capture rom_data into s1; rom_addr = p2.
  - RD3 (t+3): capture s2; rom_addr = p3.
  - CAP (t+4): capture s3; compute the mix.
  - DONE (t+5): harmonic_out is registered with the mix; sample_ready = 1 for exactly this cycle.
- Latency: request to sample_ready is exactly 5 cycles. The minimum request spacing is 6 cycles.
- In IDLE, rom_addr holds its last value.
- Mix arithmetic: sign-extend operands to 18 bits and use arithmetic shifts (>>>), truncating toward -inf per term. The sum is saturated to the 16-bit signed range.
  - w=0: s1
  - w=1: (s1>>>1)+(s1>>>3)+(s2>>>2)+(s2>>>3)
  - w=2 or 3: (s1>>>1)+(s1>>>3)+(s2>>>2)+(s3>>>3)
- note_done high while in IDLE clears p1..p3 to 0 on that cycle; go cannot be accepted simultaneously because note_done masks it. note_done asserted mid-sequence does not abort; it takes effect on return to IDLE if still high.
- play_enable low mid-sequence does not abort; the sample completes.
- Changes to weight or step_size mid-sequence have no effect on the in-flight sample.

Test Plan:
- Reset for 2 cycles -> harmonic_out=0, sample_ready=0, busy=0, rom_addr=0. Reset asserted at t+2 of a sequence -> IDLE next cycle, no sample_ready pulse, phases 0.
- step=0x00400, weight=0, single go at t from reset -> rom_addr 1,2,3 at t+1,t+2,t+3. sample_ready high only at t+5; harmonic_out=rom[1]; busy high t+1..t+5.
- Stub ROM rom[1]=800, rom[2]=1600, rom[3]=2400, step=0x00400, weight=1 -> harmonic_out=1100. Same setup with weight=2 -> 400+100+400+300=1200.
- Stub ROM returning -8 for all addresses, weight=2 -> harmonic_out=-8. With weight=3 -> identical result.
- From zero phase, step=0xFFC00 -> addrs 0x3FF, 0x3FE, 0x3FD (3*step wraps to 0xFF400).
- Extra go pulses at t+2 and t+5 -> exactly one sample_ready and one phase advance. A second go at t+6 -> next addrs 2,4,6 with step 0x00400.
- After two samples, note_done pulsed in IDLE -> next go issues addrs 1,2,3 again. go coincident with note_done -> ignored, no sample_ready.

Source files
------------

// File: rtl/harmonic_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : harmonic_sequencer
// Description : Shares one sine ROM across 1x/2x/3x phase accumulators and
//               emits one weighted, saturated harmonic sample per request.
// Revision    : 1.0 - initial release
// ============================================================================
module harmonic_sequencer #(
    parameter int PHASE_W = 20,
    parameter int ADDR_W  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play_enable,
    input  logic               generate_next_sample,
    input  logic               note_done,
    input  logic [PHASE_W-1:0] step_size,
    input  logic [1:0]         weight,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [15:0]        rom_data,
    output logic               busy,
    output logic [15:0]        harmonic_out,
    output logic               sample_ready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD1  = 3'd1,
        S_RD2  = 3'd2,
        S_RD3  = 3'd3,
        S_CAP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] p1_q, p1_d;
    logic [PHASE_W-1:0] p2_q, p2_d;
    logic [PHASE_W-1:0] p3_q, p3_d;
    logic [1:0]         weight_q, weight_d;
    logic [15:0]        s1_q, s1_d;
    logic [15:0]        s2_q, s2_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        out_q, out_d;

    logic               go;
    logic [PHASE_W-1:0] step2;
    logic [PHASE_W-1:0] step3;
    logic [PHASE_W-1:0] p1_next;
    logic signed [17:0] e1, e2, e3;
    logic signed [17:0] mix_sum;
    logic [15:0]        mix_sat;

    assign go    = generate_next_sample && play_enable && !note_done;
    assign step2 = step_size << 1;
    assign step3 = step_size + step2;
    assign p1_next = p1_q + step_size;

    // The third sample is consumed straight off the ROM bus during CAP.
    assign e1 = {{2{s1_q[15]}}, s1_q};
    assign e2 = {{2{s2_q[15]}}, s2_q};
    assign e3 = {{2{rom_data[15]}}, rom_data};

    always_comb begin
        mix_sum = e1;
        case (weight_q)
            2'd0:    mix_sum = e1;
            2'd1:    mix_sum = (e1 >>> 1) + (e1 >>> 3) + (e2 >>> 2) + (e2 >>> 3);
            default: mix_sum = (e1 >>> 1) + (e1 >>> 3) + (e2 >>> 2) + (e3 >>> 3);
        endcase
    end

    always_comb begin
        if (mix_sum > 18'sd32767) begin
            mix_sat = 16'h7FFF;
        end else if (mix_sum < -18'sd32768) begin
            mix_sat = 16'h8000;
        end else begin
            mix_sat = mix_sum[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        p3_d     = p3_q;
        weight_d = weight_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        addr_d   = addr_q;
        out_d    = out_q;
        case (state_q)
            S_IDLE: begin
                if (note_done) begin
                    p1_d = '0;
                    p2_d = '0;
                    p3_d = '0;
                end else if (go) begin
                    p1_d     = p1_next;
                    p2_d     = p2_q + step2;
                    p3_d     = p3_q + step3;
                    weight_d = weight;
                    addr_d   = p1_next[PHASE_W-1 -: ADDR_W];
                    state_d  = S_RD1;
                end
            end
            // Address for the next read is launched one state early so it
            // lines up with the ROM's registered-read latency.
            S_RD1: begin
                addr_d  = p2_q[PHASE_W-1 -: ADDR_W];
                state_d = S_RD2;
            end
            S_RD2: begin
                s1_d    = rom_data;
                addr_d  = p3_q[PHASE_W-1 -: ADDR_W];
                state_d = S_RD3;
            end
            S_RD3: begin
                s2_d    = rom_data;
                state_d = S_CAP;
            end
            S_CAP: begin
                out_d   = mix_sat;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            p1_q     <= '0;
            p2_q     <= '0;
            p3_q     <= '0;
            weight_q <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            addr_q   <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            p3_q     <= p3_d;
            weight_q <= weight_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            addr_q   <= addr_d;
            out_q    <= out_d;
        end
    end

    assign rom_addr     = addr_q;
    assign busy         = (state_q != S_IDLE);
    assign sample_ready = (state_q == S_DONE);
    assign harmonic_out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_harmonic_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_harmonic_sequencer
// Description : Directed plus randomized bench with a stub ROM and a
//               behavioural phase/mix reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_harmonic_sequencer;

    localparam int PHASE_W = 20;
    localparam int ADDR_W  = 10;
    localparam int unsigned MASK = 32'h000F_FFFF;

    logic               clk;
    logic               reset;
    logic               play_enable;
    logic               generate_next_sample;
    logic               note_done;
    logic [PHASE_W-1:0] step_size;
    logic [1:0]         weight;
    logic [ADDR_W-1:0]  rom_addr;
    logic [15:0]        rom_data;
    logic               busy;
    logic [15:0]        harmonic_out;
    logic               sample_ready;

    logic [15:0] rom [0:1023];
    int errors;
    int checks;
    int unsigned mp1, mp2, mp3;

    harmonic_sequencer #(
        .PHASE_W(PHASE_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .play_enable         (play_enable),
        .generate_next_sample(generate_next_sample),
        .note_done           (note_done),
        .step_size           (step_size),
        .weight              (weight),
        .rom_addr            (rom_addr),
        .rom_data            (rom_data),
        .busy                (busy),
        .harmonic_out        (harmonic_out),
        .sample_ready        (sample_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub sine ROM with one-cycle registered read.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fdiv(input int x, input int d);
        int q;
        q = x / d;
        if ((x % d != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    function automatic logic [15:0] ref_mix(input int s1, input int s2, input int s3, input int w);
        int v;
        if (w == 0)      v = s1;
        else if (w == 1) v = fdiv(s1, 2) + fdiv(s1, 8) + fdiv(s2, 4) + fdiv(s2, 8);
        else             v = fdiv(s1, 2) + fdiv(s1, 8) + fdiv(s2, 4) + fdiv(s3, 8);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    // Issues one request from an IDLE cycle and checks it through to t+6.
    task automatic sample(input logic [19:0] step, input logic [1:0] w, input bit extra);
        int unsigned a1, a2, a3;
        logic [15:0] exp_out;
        step_size            = step;
        weight               = w;
        play_enable          = 1'b1;
        note_done            = 1'b0;
        generate_next_sample = 1'b1;
        check("idle_busy", {31'b0, busy}, 32'd0);
        mp1 = (mp1 + step) & MASK;
        mp2 = (mp2 + 2 * step) & MASK;
        mp3 = (mp3 + 3 * step) & MASK;
        a1 = mp1 >> 10;
        a2 = mp2 >> 10;
        a3 = mp3 >> 10;
        exp_out = ref_mix(int'($signed(rom[a1])), int'($signed(rom[a2])),
                          int'($signed(rom[a3])), int'(w));
        tick();  // t+1
        generate_next_sample = 1'b0;
        play_enable          = 1'b0;
        step_size            = 20'($urandom);
        weight               = 2'($urandom);
        check("addr1", {22'b0, rom_addr}, a1);
        check("busy1", {31'b0, busy}, 32'd1);
        check("ready1", {31'b0, sample_ready}, 32'd0);
        tick();  // t+2
        play_enable          = 1'b1;
        generate_next_sample = extra;
        check("addr2", {22'b0, rom_addr}, a2);
        tick();  // t+3
        generate_next_sample = 1'b0;
        note_done            = 1'b1;
        check("addr3", {22'b0, rom_addr}, a3);
        tick();  // t+4
        check("ready4", {31'b0, sample_ready}, 32'd0);
        check("busy4", {31'b0, busy}, 32'd1);
        tick();  // t+5
        note_done            = 1'b0;
        generate_next_sample = extra;
        check("ready5", {31'b0, sample_ready}, 32'd1);
        check("busy5", {31'b0, busy}, 32'd1);
        check("out5", {16'b0, harmonic_out}, {16'b0, exp_out});
        tick();  // t+6
        generate_next_sample = 1'b0;
        check("ready6", {31'b0, sample_ready}, 32'd0);
        check("busy6", {31'b0, busy}, 32'd0);
        check("out6_hold", {16'b0, harmonic_out}, {16'b0, exp_out});
    endtask

    task automatic pulse_note_done();
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
        mp1 = 0;
        mp2 = 0;
        mp3 = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mp1 = 0;
        mp2 = 0;
        mp3 = 0;
        for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
        rom[1] = 16'd800;
        rom[2] = 16'd1600;
        rom[3] = 16'd2400;
        reset                = 1'b1;
        play_enable          = 1'b0;
        generate_next_sample = 1'b0;
        note_done            = 1'b0;
        step_size            = '0;
        weight               = '0;
        tick();
        tick();
        check("rst_out", {16'b0, harmonic_out}, 32'd0);
        check("rst_ready", {31'b0, sample_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_addr", {22'b0, rom_addr}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic w=0, extra requests dropped, then back-to-back at t+6.
        sample(20'h00400, 2'd0, 1'b1);
        sample(20'h00400, 2'd1, 1'b0);

        pulse_note_done();
        sample(20'h00400, 2'd1, 1'b0);
        check("w1_1100", {16'b0, harmonic_out}, 32'd1100);
        pulse_note_done();
        sample(20'h00400, 2'd2, 1'b0);
        check("w2_1200", {16'b0, harmonic_out}, 32'd1200);

        for (int i = 0; i < 1024; i++) rom[i] = 16'hFFF8;
        sample(20'h01234, 2'd2, 1'b0);
        check("w2_neg8", {16'b0, harmonic_out}, 32'h0000FFF8);
        sample(20'h01234, 2'd3, 1'b0);
        check("w3_neg8", {16'b0, harmonic_out}, 32'h0000FFF8);

        // Reset in the middle of a sequence.
        generate_next_sample = 1'b1;
        play_enable          = 1'b1;
        step_size            = 20'h00400;
        weight               = 2'd0;
        tick();  // t+1
        generate_next_sample = 1'b0;
        tick();  // t+2
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mp1 = 0;
        mp2 = 0;
        mp3 = 0;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_out", {16'b0, harmonic_out}, 32'd0);
        check("midrst_addr", {22'b0, rom_addr}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midrst_noready", {31'b0, sample_ready}, 32'd0);
        end

        for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
        sample(20'hFFC00, 2'd2, 1'b0);

        // Request coincident with note_done, then one with play disabled.
        generate_next_sample = 1'b1;
        note_done            = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        note_done            = 1'b0;
        mp1 = 0;
        mp2 = 0;
        mp3 = 0;
        for (int i = 0; i < 6; i++) begin
            check("nd_go_busy", {31'b0, busy}, 32'd0);
            check("nd_go_ready", {31'b0, sample_ready}, 32'd0);
            tick();
        end
        play_enable          = 1'b0;
        generate_next_sample = 1'b1;
        tick();
        generate_next_sample = 1'b0;
        check("pe0_busy", {31'b0, busy}, 32'd0);
        sample(20'h00400, 2'd0, 1'b0);

        for (int i = 0; i < 1024; i++) begin
            if ($urandom_range(0, 15) == 0) rom[i] = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
            else rom[i] = 16'($urandom);
        end
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 4) == 0) pulse_note_done();
            if ($urandom_range(0, 4) == 0) begin
                play_enable          = 1'b0;
                generate_next_sample = 1'b1;
                tick();
                generate_next_sample = 1'b0;
                check("rand_pe0_busy", {31'b0, busy}, 32'd0);
            end
            sample(20'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
